dw_arb_wrr: RTL and testbench

DW_ARB_WRR -- requirements
Module: dw_arb_wrr

---
 rtl/dw_arb_pkg.sv | 36 +++
 rtl/dw_arb_wrr_if.sv | 30 +++
 rtl/dw_arb_rr_pick.sv | 31 +++
 rtl/dw_arb_wrr.sv | 140 ++++++++++++++
 tb/tb_dw_arb_wrr.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dw_arb_pkg.sv
// Shared constants and helpers for the weighted round-robin arbiter.
package dw_arb_pkg;

  // Legal parameter ranges
  localparam int N_MIN  = 2;
  localparam int N_MAX  = 32;
  localparam int WW_MIN = 1;
  localparam int WW_MAX = 8;

  // OUTPUT_MODE encodings
  localparam int OUT_MODE_COMB = 0;
  localparam int OUT_MODE_REG  = 1;

  // PARK_MODE encodings
  localparam int PARK_OFF = 0;
  localparam int PARK_ON  = 1;

  // Per-cycle arbitration decision
  typedef enum logic [1:0] {
    DEC_OFF    = 2'd0,
    DEC_KEEP   = 2'd1,
    DEC_SWITCH = 2'd2,
    DEC_IDLE   = 2'd3
  } dec_e;

  // Ceiling log2, never below 1 so a 2-client arbiter still gets a 1-bit index
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/dw_arb_wrr_if.sv
// Request/grant bundle between clients and the weighted round-robin arbiter.
interface dw_arb_wrr_if #(
  parameter int N  = 4,
  parameter int WW = 4
);
  import dw_arb_pkg::*;

  localparam int IW = clog2(N);

  logic            init_n;
  logic            enable;
  logic [N-1:0]    request;
  logic [N-1:0]    mask;
  logic [N-1:0]    lock;
  logic [N*WW-1:0] weight;
  logic            granted;
  logic [N-1:0]    grant;
  logic [IW-1:0]   grant_index;

  modport master (
    output init_n, enable, request, mask, lock, weight,
    input  granted, grant, grant_index
  );

  modport slave (
    input  init_n, enable, request, mask, lock, weight,
    output granted, grant, grant_index
  );

endinterface

// File: rtl/dw_arb_rr_pick.sv
// Rotating-priority search: first set bit of mreq at or after start, with wrap.
module dw_arb_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  mreq,
  input  logic [IW-1:0] start,
  output logic [IW-1:0] winner,
  output logic          valid
);

  localparam logic [IW:0] NV = (IW + 1)'(N);

  logic [IW:0] idx;

  // Walk clients start, start+1, ... modulo N; the lowest offset with a request wins
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, start} + (IW + 1)'(k);
      if (idx >= NV) idx = idx - NV;
      if (!valid && mreq[idx[IW-1:0]]) begin
        valid  = 1'b1;
        winner = idx[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/dw_arb_wrr.sv
// Weighted round-robin arbiter with lock, mask, optional parking and
// selectable registered or combinational outputs.
module dw_arb_wrr
  import dw_arb_pkg::*;
#(
  parameter int N           = 4,
  parameter int WW          = 4,
  parameter int OUTPUT_MODE = 1,
  parameter int PARK_MODE   = 0,
  parameter int PARK_INDEX  = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  dw_arb_wrr_if.slave bus
);

  localparam int IW = clog2(N);

  // Elaboration-time parameter range checks
  if (N < N_MIN || N > N_MAX) begin : g_bad_n
    $error("dw_arb_wrr: N out of range");
  end
  if (WW < WW_MIN || WW > WW_MAX) begin : g_bad_ww
    $error("dw_arb_wrr: WW out of range");
  end
  if (OUTPUT_MODE != OUT_MODE_COMB && OUTPUT_MODE != OUT_MODE_REG) begin : g_bad_om
    $error("dw_arb_wrr: OUTPUT_MODE must be 0 or 1");
  end
  if (PARK_MODE != PARK_OFF && PARK_MODE != PARK_ON) begin : g_bad_pm
    $error("dw_arb_wrr: PARK_MODE must be 0 or 1");
  end
  if (PARK_INDEX < 0 || PARK_INDEX > N - 1) begin : g_bad_pi
    $error("dw_arb_wrr: PARK_INDEX out of range");
  end

  localparam logic [IW-1:0] LAST       = IW'(N - 1);
  localparam logic [IW-1:0] PARK_IDX_V = IW'(PARK_INDEX);
  localparam logic [N-1:0]  ONE        = N'(1);
  localparam logic [N-1:0]  PARK_VEC   = ONE << PARK_INDEX;

  logic [IW-1:0] owner_reg, owner_next;
  logic [WW-1:0] credit_reg, credit_next;
  logic          granted_reg, granted_next;
  logic [N-1:0]  grant_reg, grant_next;
  logic [IW-1:0] index_reg, index_next;

  logic [N-1:0]  mreq;
  logic [IW-1:0] start;
  logic [IW-1:0] pick_winner;
  logic          pick_valid;
  logic [WW-1:0] eff_w [N];
  dec_e          dec;

  assign mreq  = bus.request & ~bus.mask;
  assign start = (owner_reg == LAST) ? '0 : owner_reg + IW'(1);

  // A programmed weight of zero behaves as one
  for (genvar gi = 0; gi < N; gi++) begin : g_eff_w
    assign eff_w[gi] = (bus.weight[gi*WW +: WW] == '0) ? WW'(1) : bus.weight[gi*WW +: WW];
  end

  dw_arb_rr_pick #(.N(N), .IW(IW)) u_pick (
    .mreq   (mreq),
    .start  (start),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  // Decide keep / switch / idle and form the next state and output values
  always_comb begin
    owner_next   = owner_reg;
    credit_next  = credit_reg;
    granted_next = 1'b0;
    grant_next   = '0;
    index_next   = '0;
    dec          = DEC_OFF;
    if (!bus.init_n) begin
      owner_next  = LAST;
      credit_next = '0;
    end else if (bus.enable) begin
      if (granted_reg && mreq[owner_reg] && (bus.lock[owner_reg] || credit_reg > WW'(1)))
        dec = DEC_KEEP;
      else if (pick_valid)
        dec = DEC_SWITCH;
      else
        dec = DEC_IDLE;
    end
    case (dec)
      DEC_KEEP: begin
        granted_next = 1'b1;
        grant_next   = ONE << owner_reg;
        index_next   = owner_reg;
        if (!bus.lock[owner_reg]) credit_next = credit_reg - WW'(1);
      end
      DEC_SWITCH: begin
        owner_next   = pick_winner;
        credit_next  = eff_w[pick_winner];
        granted_next = 1'b1;
        grant_next   = ONE << pick_winner;
        index_next   = pick_winner;
      end
      DEC_IDLE: begin
        if (PARK_MODE == PARK_ON) begin
          grant_next = PARK_VEC;
          index_next = PARK_IDX_V;
        end
      end
      default: ;
    endcase
  end

  // State register; reset leaves owner at N-1 so the first search starts at client 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_reg   <= LAST;
      credit_reg  <= '0;
      granted_reg <= 1'b0;
      grant_reg   <= '0;
      index_reg   <= '0;
    end else begin
      owner_reg   <= owner_next;
      credit_reg  <= credit_next;
      granted_reg <= granted_next;
      grant_reg   <= grant_next;
      index_reg   <= index_next;
    end
  end

  // Registered outputs, or same-cycle decision forced to zero during reset
  if (OUTPUT_MODE == OUT_MODE_REG) begin : g_out_reg
    assign bus.granted     = granted_reg;
    assign bus.grant       = grant_reg;
    assign bus.grant_index = index_reg;
  end else begin : g_out_comb
    assign bus.granted     = rst_n & granted_next;
    assign bus.grant       = rst_n ? grant_next : '0;
    assign bus.grant_index = rst_n ? index_next : '0;
  end

endmodule

// File: tb/tb_dw_arb_wrr.sv
// Self-checking bench: three arbiter configurations share one stimulus stream
// and are compared against a behavioural model of the arbitration rules.
module tb_dw_arb_wrr;
  localparam int N = 4, WW = 4, IW = 2, PARK_IDX = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_n = 1'b1, enable = 1'b0;
  logic [N-1:0] request = '0, mask = '0, lock = '0;
  logic [N*WW-1:0] weight = '0;

  int errors = 0, checks = 0, cyc = 0;

  // model state and per-cycle expectations
  int m_owner, m_left, n_owner, n_left, e_idx_i;
  bit m_granted, e_granted, e_idle;
  logic [N-1:0] e_grant, e_pgrant;
  logic [IW-1:0] e_idx, e_pidx;

  always #5 clk = ~clk;

  dw_arb_wrr_if #(.N(N), .WW(WW)) if_r ();
  dw_arb_wrr_if #(.N(N), .WW(WW)) if_p ();
  dw_arb_wrr_if #(.N(N), .WW(WW)) if_c ();

  dw_arb_wrr #(.N(N), .WW(WW), .OUTPUT_MODE(1), .PARK_MODE(0), .PARK_INDEX(0))
    dut_r (.clk(clk), .rst_n(rst_n), .bus(if_r.slave));
  dw_arb_wrr #(.N(N), .WW(WW), .OUTPUT_MODE(1), .PARK_MODE(1), .PARK_INDEX(PARK_IDX))
    dut_p (.clk(clk), .rst_n(rst_n), .bus(if_p.slave));
  dw_arb_wrr #(.N(N), .WW(WW), .OUTPUT_MODE(0), .PARK_MODE(0), .PARK_INDEX(0))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));

  assign if_r.init_n = init_n;  assign if_p.init_n = init_n;  assign if_c.init_n = init_n;
  assign if_r.enable = enable;  assign if_p.enable = enable;  assign if_c.enable = enable;
  assign if_r.request = request; assign if_p.request = request; assign if_c.request = request;
  assign if_r.mask = mask;      assign if_p.mask = mask;      assign if_c.mask = mask;
  assign if_r.lock = lock;      assign if_p.lock = lock;      assign if_c.lock = lock;
  assign if_r.weight = weight;  assign if_p.weight = weight;  assign if_c.weight = weight;

  task automatic model_reset();
    m_owner = N - 1; m_left = 0; m_granted = 1'b0;
  endtask

  // Arbitration rules expressed directly: keep the turn while credit remains or
  // locked, else next requester after the owner in circular order.
  task automatic model_eval();
    logic [N-1:0] mreq;
    int c, w;
    mreq = request & ~mask;
    n_owner = m_owner; n_left = m_left;
    e_granted = 1'b0; e_idle = 1'b0; e_idx_i = 0;
    if (!init_n) begin
      n_owner = N - 1; n_left = 0;
    end else if (enable) begin
      if (m_granted && mreq[m_owner] && (lock[m_owner] || m_left > 1)) begin
        e_granted = 1'b1; e_idx_i = m_owner;
        if (!lock[m_owner]) n_left = m_left - 1;
      end else if (mreq != '0) begin
        for (int k = 1; k <= N; k++) begin
          c = (m_owner + k) % N;
          if (mreq[c] && !e_granted) begin e_granted = 1'b1; e_idx_i = c; end
        end
        w = int'(weight[e_idx_i*WW +: WW]);
        n_owner = e_idx_i; n_left = (w == 0) ? 1 : w;
      end else begin
        e_idle = 1'b1;
      end
    end
    e_grant  = e_granted ? (N'(1) << e_idx_i) : '0;
    e_idx    = e_granted ? IW'(e_idx_i) : '0;
    e_pgrant = e_granted ? e_grant : (e_idle ? (N'(1) << PARK_IDX) : '0);
    e_pidx   = e_granted ? e_idx : (e_idle ? IW'(PARK_IDX) : '0);
  endtask

  task automatic settle();
    model_eval();
    #1;
  endtask

  task automatic clk_edge();
    @(posedge clk); #1;
    m_owner = n_owner; m_left = n_left; m_granted = e_granted;
    cyc++;
    $display("cyc=%0d en=%b init_n=%b req=%b mask=%b lock=%b -> r:%b/%0d p:%b/%0d c:%b",
             cyc, enable, init_n, request, mask, lock, if_r.grant, if_r.grant_index,
             if_p.grant, if_p.grant_index, if_c.grant);
  endtask

  task automatic do_reset();
    request = '0; mask = '0; lock = '0; enable = 1'b1; init_n = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    weight = 16'h1111; request = 4'b1111;
    settle(); clk_edge(); settle(); clk_edge();
    #2 rst_n = 1'b0; #1;
    model_reset();
    checks++; if ({if_r.granted, if_r.grant, if_r.grant_index} !== '0) begin errors++;
      $display("FAIL reset_async_r: got %b/%b/%0d want 0/0000/0", if_r.granted, if_r.grant, if_r.grant_index); end
    @(posedge clk); #1;
    checks++; if ({if_p.granted, if_p.grant, if_p.grant_index} !== '0) begin errors++;
      $display("FAIL reset_p: got %b/%b/%0d want 0/0000/0", if_p.granted, if_p.grant, if_p.grant_index); end
    checks++; if ({if_c.granted, if_c.grant, if_c.grant_index} !== '0) begin errors++;
      $display("FAIL reset_c: got %b/%b/%0d want 0/0000/0", if_c.granted, if_c.grant, if_c.grant_index); end
    rst_n = 1'b1;
    settle();
    checks++; if (if_c.grant !== 4'b0001) begin errors++;
      $display("FAIL reset_first_c: got %b want 0001", if_c.grant); end
    clk_edge();
    checks++; if (if_r.grant !== 4'b0001 || if_r.granted !== 1'b1) begin errors++;
      $display("FAIL reset_first_r: got %b/%b want 0001/1", if_r.grant, if_r.granted); end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    weight = 16'h1111; request = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      settle();
      checks++; if (if_c.grant !== exp_seq[k]) begin errors++;
        $display("FAIL rotation_c[%0d]: got %b want %b", k, if_c.grant, exp_seq[k]); end
      clk_edge();
      checks++; if (if_r.grant !== exp_seq[k]) begin errors++;
        $display("FAIL rotation_r[%0d]: got %b want %b", k, if_r.grant, exp_seq[k]); end
    end
  endtask

  task automatic test_weighted();
    logic [3:0] want;
    do_reset();
    weight = 16'h0003; request = 4'b0011;
    for (int k = 0; k < 8; k++) begin
      want = ((k % 4) < 3) ? 4'b0001 : 4'b0010;
      settle(); clk_edge();
      checks++; if (if_r.grant !== want) begin errors++;
        $display("FAIL weighted[%0d]: got %b want %b", k, if_r.grant, want); end
    end
  endtask

  task automatic test_lock_mask();
    logic [3:0] exp_lock [6] = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
    logic [3:0] want;
    do_reset();
    weight = 16'h1111; request = 4'b0011; lock = 4'b0010;
    for (int k = 0; k < 6; k++) begin
      settle(); clk_edge();
      checks++; if (if_r.grant !== exp_lock[k]) begin errors++;
        $display("FAIL lock_hold[%0d]: got %b want %b", k, if_r.grant, exp_lock[k]); end
    end
    lock = 4'b0000;
    settle(); clk_edge();
    checks++; if (if_r.grant !== 4'b0001) begin errors++;
      $display("FAIL lock_release: got %b want 0001", if_r.grant); end
    request = 4'b1111; mask = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      want = (k % 2 == 0) ? 4'b0010 : 4'b1000;
      settle(); clk_edge();
      checks++; if (if_r.grant !== want) begin errors++;
        $display("FAIL mask_alt[%0d]: got %b want %b", k, if_r.grant, want); end
    end
  endtask

  task automatic test_init_park();
    do_reset();
    weight = 16'h1111; request = 4'b1000;
    for (int k = 0; k < 2; k++) begin
      settle(); clk_edge();
      checks++; if (if_p.grant !== 4'b1000 || if_p.granted !== 1'b1) begin errors++;
        $display("FAIL park_pre[%0d]: got %b/%b want 1000/1", k, if_p.grant, if_p.granted); end
    end
    init_n = 1'b0; request = 4'b0000;
    settle(); clk_edge();
    checks++; if (if_p.granted !== 1'b0) begin errors++;
      $display("FAIL init_granted: got %b want 0", if_p.granted); end
    init_n = 1'b1;
    settle(); clk_edge();
    checks++; if (if_p.grant !== 4'b0100 || if_p.granted !== 1'b0 || if_p.grant_index !== 2'd2) begin errors++;
      $display("FAIL park_vec: got %b/%b/%0d want 0100/0/2", if_p.grant, if_p.granted, if_p.grant_index); end
    checks++; if (if_r.grant !== 4'b0000 || if_r.grant_index !== 2'd0) begin errors++;
      $display("FAIL idle_nopark: got %b/%0d want 0000/0", if_r.grant, if_r.grant_index); end
    request = 4'b1000;
    settle(); clk_edge();
    checks++; if (if_p.grant !== 4'b1000 || if_p.granted !== 1'b1 || if_p.grant_index !== 2'd3) begin errors++;
      $display("FAIL park_regrant: got %b/%b/%0d want 1000/1/3", if_p.grant, if_p.granted, if_p.grant_index); end
  endtask

  task automatic test_comb_mode();
    do_reset();
    weight = 16'h1111; request = 4'b0000;
    settle(); clk_edge();
    request = 4'b0100;
    settle();
    checks++; if (if_c.grant !== 4'b0100 || if_c.grant_index !== 2'd2 || if_c.granted !== 1'b1) begin errors++;
      $display("FAIL comb_same_cycle: got %b/%0d/%b want 0100/2/1", if_c.grant, if_c.grant_index, if_c.granted); end
    checks++; if (if_r.granted !== 1'b0) begin errors++;
      $display("FAIL reg_latency: got %b want 0", if_r.granted); end
    clk_edge();
    checks++; if (if_r.grant !== 4'b0100) begin errors++;
      $display("FAIL reg_after_edge: got %b want 0100", if_r.grant); end
  endtask

  task automatic test_random();
    do_reset();
    weight = 16'($urandom);
    for (int k = 0; k < 400; k++) begin
      enable = ($urandom_range(0, 9) != 0);
      init_n = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 9) < 3) request = N'($urandom);
      mask = N'($urandom & $urandom & $urandom);
      lock = ($urandom_range(0, 5) == 0) ? N'($urandom & $urandom) : '0;
      if ($urandom_range(0, 7) == 0) weight = 16'($urandom);
      settle();
      checks++; if ({if_c.granted, if_c.grant, if_c.grant_index} !== {e_granted, e_grant, e_idx}) begin errors++;
        $display("FAIL rand_c[%0d]: got %b/%b/%0d want %b/%b/%0d", k, if_c.granted, if_c.grant,
                 if_c.grant_index, e_granted, e_grant, e_idx); end
      clk_edge();
      checks++; if ({if_r.granted, if_r.grant, if_r.grant_index} !== {e_granted, e_grant, e_idx}) begin errors++;
        $display("FAIL rand_r[%0d]: got %b/%b/%0d want %b/%b/%0d", k, if_r.granted, if_r.grant,
                 if_r.grant_index, e_granted, e_grant, e_idx); end
      checks++; if ({if_p.granted, if_p.grant, if_p.grant_index} !== {e_granted, e_pgrant, e_pidx}) begin errors++;
        $display("FAIL rand_p[%0d]: got %b/%b/%0d want %b/%b/%0d", k, if_p.granted, if_p.grant,
                 if_p.grant_index, e_granted, e_pgrant, e_pidx); end
      checks++; if ($countones(if_r.grant) > 1) begin errors++;
        $display("FAIL rand_onehot[%0d]: got %b want one-hot or zero", k, if_r.grant); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rotation();
    test_weighted();
    test_lock_mask();
    test_init_park();
    test_comb_mode();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
